// File: rtl/level_encoding.sv
// Level (non-trailing-one coefficient) encoder for a CAVLC-style residual block.
// Accepts one level per handshake and emits one prefix/suffix codeword per level.
module level_encoding (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  TotalCoeff,
  input  logic [1:0]  TrailingOnes,
  input  logic [15:0] level_in,
  input  logic        level_valid,
  output logic        level_ready,
  output logic [27:0] code_word,
  output logic [4:0]  code_len,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StLoad, StCode, StEmit, StDone} state_t;

  state_t      state_q;
  logic [15:0] level_q;
  logic [4:0]  n_q;
  logic [4:0]  cnt_q;
  logic [1:0]  t1_q;
  logic [2:0]  sl_q;

  logic [16:0] lvl_s, abs_lvl, level_code, base, esc, shifted, mask, sfx, thresh;
  logic [3:0]  prefix, ssize;
  logic [11:0] suffix;
  logic        first_sub, bad, ovf, err_n;
  logic [2:0]  sl1, sl_n;
  logic [4:0]  len_n;
  logic [27:0] word_n;

  always_comb begin
    lvl_s      = {level_q[15], level_q};
    abs_lvl    = level_q[15] ? (17'd0 - lvl_s) : lvl_s;
    first_sub  = (cnt_q == 5'd0) && (t1_q != 2'd3);
    if (!level_q[15] && (level_q != 16'd0)) level_code = {abs_lvl[15:0], 1'b0} - 17'd2;
    else                                    level_code = {abs_lvl[15:0], 1'b0} - 17'd1;
    if (first_sub) level_code = level_code - 17'd2;

    // Inputs that cannot produce a legal levelCode go straight to a clamped escape.
    bad = (level_q == 16'd0) || (level_q == 16'h8000) || (first_sub && (abs_lvl == 17'd1));

    base    = (sl_q == 3'd0) ? 17'd30 : (17'd15 << sl_q);
    shifted = level_code >> sl_q;
    mask    = (17'd1 << sl_q) - 17'd1;
    sfx     = level_code & mask;
    esc     = level_code - base;
    ovf     = 1'b0;
    prefix  = 4'd15;
    ssize   = 4'd12;
    suffix  = 12'hFFF;
    if (bad) begin
      ovf = 1'b0;
    end else if ((sl_q == 3'd0) && (level_code < 17'd14)) begin
      prefix = level_code[3:0];
      ssize  = 4'd0;
      suffix = 12'd0;
    end else if ((sl_q == 3'd0) && (level_code < 17'd30)) begin
      prefix = 4'd14;
      ssize  = 4'd4;
      suffix = {8'd0, level_code[3:0] - 4'd14};
    end else if ((sl_q != 3'd0) && (level_code < base)) begin
      prefix = shifted[3:0];
      ssize  = {1'b0, sl_q};
      suffix = sfx[11:0];
    end else if (esc > 17'd4095) begin
      ovf = 1'b1;
    end else begin
      suffix = esc[11:0];
    end
    err_n  = bad | ovf;
    len_n  = {1'b0, prefix} + 5'd1 + {1'b0, ssize};
    word_n = (28'd1 << ssize) | {16'd0, suffix};

    sl1    = (sl_q == 3'd0) ? 3'd1 : sl_q;
    thresh = 17'd3 << (sl1 - 3'd1);
    sl_n   = ((abs_lvl > thresh) && (sl1 < 3'd6)) ? sl1 + 3'd1 : sl1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      level_q     <= 16'd0;
      n_q         <= 5'd0;
      cnt_q       <= 5'd0;
      t1_q        <= 2'd0;
      sl_q        <= 3'd0;
      level_ready <= 1'b0;
      code_word   <= 28'd0;
      code_len    <= 5'd0;
      code_valid  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err   <= 1'b0;
            n_q   <= TotalCoeff - {3'd0, TrailingOnes};
            t1_q  <= TrailingOnes;
            cnt_q <= 5'd0;
            sl_q  <= ((TotalCoeff > 5'd10) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
            if (TotalCoeff == {3'd0, TrailingOnes}) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q     <= StLoad;
              level_ready <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (level_valid && level_ready) begin
            level_q     <= level_in;
            level_ready <= 1'b0;
            state_q     <= StCode;
          end
        end
        StCode: begin
          code_word  <= word_n;
          code_len   <= len_n;
          code_valid <= 1'b1;
          err        <= err | err_n;
          sl_q       <= sl_n;
          cnt_q      <= cnt_q + 5'd1;
          state_q    <= StEmit;
        end
        StEmit: begin
          if (code_ready) begin
            code_valid <= 1'b0;
            if (cnt_q < n_q) begin
              state_q     <= StLoad;
              level_ready <= 1'b1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_level_encoding.sv
// Directed bench for level_encoding: hand-computed codewords, handshake timing and reset.
module tb_level_encoding;

  logic        clk, reset_n, start, level_valid, level_ready, code_valid, code_ready, done, err;
  logic [4:0]  TotalCoeff, code_len;
  logic [1:0]  TrailingOnes;
  logic [15:0] level_in;
  logic [27:0] code_word;
  int          n_tests, n_fail;

  level_encoding dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .TotalCoeff  (TotalCoeff),
    .TrailingOnes(TrailingOnes),
    .level_in    (level_in),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .code_word   (code_word),
    .code_len    (code_len),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] tc, input logic [1:0] t1);
    start = 1'b1; TotalCoeff = tc; TrailingOnes = t1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_level(input logic [15:0] lvl);
    level_in = lvl; level_valid = 1'b1;
    for (int i = 0; i < 20 && level_ready !== 1'b1; i++) tick();
    n_tests++;
    if (level_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_level timeout: level_ready=%b required 1", level_ready);
    end
    tick();
    level_valid = 1'b0;
  endtask

  task automatic wait_code;
    for (int i = 0; i < 20 && code_valid !== 1'b1; i++) tick();
    n_tests++;
    if (code_valid !== 1'b1) begin
      n_fail++; $display("FAIL wait_code timeout: code_valid=%b required 1", code_valid);
    end
  endtask

  task automatic accept;
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({level_ready, code_valid, done, err, code_len, code_word} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset.outputs: rdy=%b vld=%b done=%b err=%b len=%0d word=%h required all 0",
               level_ready, code_valid, done, err, code_len, code_word);
    end
    reset_n = 1'b1;
    tick();
  endtask

  // TC=3, T1=1: +2 -> levelCode 0, -3 -> levelCode 5 with sL=1.
  task automatic test_two_levels;
    do_start(5'd3, 2'd1);
    level_in = 16'd2; level_valid = 1'b1;
    n_tests++;
    if (level_ready !== 1'b1) begin
      n_fail++; $display("FAIL two.ready: level_ready=%b required 1", level_ready);
    end
    tick();
    level_valid = 1'b0;
    n_tests++;
    if (code_valid !== 1'b0) begin
      n_fail++; $display("FAIL two.latency_code: code_valid=%b required 0", code_valid);
    end
    tick();
    n_tests++;
    if (code_valid !== 1'b1 || code_len !== 5'd1 || code_word !== 28'h1) begin
      n_fail++;
      $display("FAIL two.first: vld=%b len=%0d word=%h required 1 1 1", code_valid, code_len,
               code_word);
    end
    accept();
    send_level(16'hFFFD);
    wait_code();
    n_tests++;
    if (code_len !== 5'd4 || code_word !== 28'h3) begin
      n_fail++; $display("FAIL two.second: len=%0d word=%h required 4 3", code_len, code_word);
    end
    accept();
    n_tests++;
    if (done !== 1'b1 || err !== 1'b0 || code_valid !== 1'b0) begin
      n_fail++; $display("FAIL two.done: done=%b err=%b vld=%b required 1 0 0", done, err,
                         code_valid);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL two.done_pulse: done=%b required 0", done);
    end
  endtask

  // +11 -> prefix 14, 4-bit suffix 6; sL becomes 2 so +4 -> prefix 1, 2-bit suffix 2.
  task automatic test_suffix_sl0;
    do_start(5'd5, 2'd3);
    send_level(16'd11);
    wait_code();
    n_tests++;
    if (code_len !== 5'd19 || code_word !== 28'h16) begin
      n_fail++; $display("FAIL sl0.len19: len=%0d word=%h required 19 16", code_len, code_word);
    end
    accept();
    send_level(16'd4);
    wait_code();
    n_tests++;
    if (code_len !== 5'd4 || code_word !== 28'h6) begin
      n_fail++; $display("FAIL sl0.sl2: len=%0d word=%h required 4 6", code_len, code_word);
    end
    accept();
    tick();
  endtask

  task automatic test_escape;
    do_start(5'd4, 2'd3);
    send_level(16'd20);
    wait_code();
    n_tests++;
    if (code_len !== 5'd28 || code_word !== 28'h1008 || err !== 1'b0) begin
      n_fail++; $display("FAIL esc.20: len=%0d word=%h err=%b required 28 1008 0", code_len,
                         code_word, err);
    end
    accept(); tick();
    do_start(5'd4, 2'd3);
    send_level(16'd2100);
    wait_code();
    n_tests++;
    if (code_len !== 5'd28 || code_word !== 28'h1FFF || err !== 1'b1) begin
      n_fail++; $display("FAIL esc.clamp: len=%0d word=%h err=%b required 28 1fff 1", code_len,
                         code_word, err);
    end
    accept(); tick();
    do_start(5'd4, 2'd3);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL esc.err_clear: err=%b required 0", err);
    end
    send_level(16'd0);
    wait_code();
    n_tests++;
    if (code_word !== 28'h1FFF || err !== 1'b1) begin
      n_fail++; $display("FAIL esc.zero: word=%h err=%b required 1fff 1", code_word, err);
    end
    accept(); tick();
    do_start(5'd4, 2'd3);
    send_level(16'h8000);
    wait_code();
    n_tests++;
    if (code_word !== 28'h1FFF || err !== 1'b1) begin
      n_fail++; $display("FAIL esc.min: word=%h err=%b required 1fff 1", code_word, err);
    end
    accept(); tick();
  endtask

  // TC=11, T1=0 starts at sL=1; -2 -> levelCode 3-2=1.
  task automatic test_sl_init;
    do_start(5'd11, 2'd0);
    send_level(16'hFFFE);
    wait_code();
    n_tests++;
    if (code_len !== 5'd2 || code_word !== 28'h3) begin
      n_fail++; $display("FAIL slinit: len=%0d word=%h required 2 3", code_len, code_word);
    end
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
  endtask

  task automatic test_backpressure;
    do_start(5'd4, 2'd3);
    send_level(16'd5);
    wait_code();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (code_valid !== 1'b1 || code_len !== 5'd9 || code_word !== 28'h1 ||
          level_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp.hold%0d: vld=%b len=%0d word=%h rdy=%b required 1 9 1 0", i,
                 code_valid, code_len, code_word, level_ready);
      end
    end
    accept();
    n_tests++;
    if (code_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL bp.advance: vld=%b done=%b required 0 1", code_valid, done);
    end
    tick();
  endtask

  task automatic test_no_levels;
    do_start(5'd3, 2'd3);
    n_tests++;
    if (done !== 1'b1 || level_ready !== 1'b0) begin
      n_fail++; $display("FAIL nolev.done: done=%b rdy=%b required 1 0", done, level_ready);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || level_ready !== 1'b0) begin
      n_fail++; $display("FAIL nolev.after: done=%b rdy=%b required 0 0", done, level_ready);
    end
  endtask

  task automatic test_reset_in_emit;
    do_start(5'd4, 2'd3);
    send_level(16'd11);
    wait_code();
    reset_n = 1'b0;
    tick();
    n_tests++;
    if ({level_ready, code_valid, done, err, code_len, code_word} !== 37'd0) begin
      n_fail++;
      $display("FAIL rst_emit: rdy=%b vld=%b done=%b err=%b len=%0d word=%h required all 0",
               level_ready, code_valid, done, err, code_len, code_word);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (code_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_emit.stays: code_valid=%b required 0", code_valid);
    end
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; start = 1'b0; TotalCoeff = 5'd0; TrailingOnes = 2'd0;
    level_in = 16'd0; level_valid = 1'b0; code_ready = 1'b0;
    n_tests = 0; n_fail = 0;
    test_reset();
    test_two_levels();
    test_suffix_sl0();
    test_escape();
    test_sl_init();
    test_backpressure();
    test_no_levels();
    test_reset_in_emit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
